// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types, widths and PC helpers
package fetch_pkg;

    localparam int PC_W          = 32;
    localparam int DEF_BTB_IDX_W = 5;
    localparam int TAG_W         = 30 - DEF_BTB_IDX_W;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [29:0]      target;
    } btb_entry_t;

    // Sequential fetch address; wraps modulo 2**32.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_pc_btb_if.sv
// rtl/fetch_pc_btb_if.sv - fetch next-PC unit signal bundle (hazard/BPU/B-stage side vs. fetch side)
interface fetch_pc_btb_if;
    import fetch_pkg::*;

    logic            StallF;
    logic            BP;
    logic            BranchB;
    logic            ZeroB;
    logic [PC_W-1:0] PCB;
    logic [PC_W-1:0] TargetB;
    logic            PredTakenB;
    logic [PC_W-1:0] PredTargetB;

    logic [PC_W-1:0] PCF;
    logic            BTBHitF;
    logic            PredTakenF;
    logic [PC_W-1:0] PredTargetF;
    logic            MispredictB;

    modport master (
        output StallF, BP, BranchB, ZeroB, PCB, TargetB, PredTakenB, PredTargetB,
        input  PCF, BTBHitF, PredTakenF, PredTargetF, MispredictB
    );

    modport slave (
        input  StallF, BP, BranchB, ZeroB, PCB, TargetB, PredTakenB, PredTargetB,
        output PCF, BTBHitF, PredTakenF, PredTargetF, MispredictB
    );

endinterface

// File: rtl/fetch_pc_btb_btb_array.sv
// rtl/fetch_pc_btb_btb_array.sv - direct-mapped BTB storage: async read on fetch PC, sync write from B stage
module btb_array
    import fetch_pkg::*;
#(
    parameter int IDX_W = DEF_BTB_IDX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] rd_word,
    output logic        rd_hit,
    output logic [29:0] rd_target,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  logic [29:0] wr_target
);

    localparam int ENT_TAG_W = 30 - IDX_W;
    localparam int DEPTH     = 1 << IDX_W;

    logic [DEPTH-1:0]     valid;
    logic [ENT_TAG_W-1:0] tags    [DEPTH];
    logic [29:0]          targets [DEPTH];

    logic [IDX_W-1:0]     rd_idx;
    logic [ENT_TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0]     wr_idx;
    logic [ENT_TAG_W-1:0] wr_tag;

    assign rd_idx = rd_word[IDX_W-1:0];
    assign rd_tag = rd_word[29:IDX_W];
    assign wr_idx = wr_word[IDX_W-1:0];
    assign wr_tag = wr_word[29:IDX_W];

    // Read sees pre-edge contents, so a same-cycle write to the same index is not bypassed.
    assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_target = targets[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/fetch_pc_btb.sv
// rtl/fetch_pc_btb.sv - fetch PC register, BTB lookup/update, B-stage mispredict detect and redirect
module fetch_pc_btb
    import fetch_pkg::*;
#(
    parameter int              BTB_IDX_W = DEF_BTB_IDX_W,
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fetch_pc_btb_if.slave bus
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pred_target;
    logic [PC_W-1:0] redirect_pc;
    logic            hit;
    logic [29:0]     btb_target;
    logic            wrong_dir;
    logic            wrong_tgt;
    logic            mispredict;
    logic            btb_wr;
    logic            unused_low_bits;

    btb_array #(
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_word   (pc_q[31:2]),
        .rd_hit    (hit),
        .rd_target (btb_target),
        .wr_en     (btb_wr),
        .wr_word   (bus.PCB[31:2]),
        .wr_target (bus.TargetB[31:2])
    );

    assign pc_seq      = pc_plus4(pc_q);
    assign pred_target = hit ? {btb_target, 2'b00} : pc_seq;

    // Only the word address of a target matters; byte-offset bits are dropped everywhere.
    assign wrong_dir  = bus.ZeroB != bus.PredTakenB;
    assign wrong_tgt  = bus.ZeroB && bus.PredTakenB &&
                        (bus.TargetB[31:2] != bus.PredTargetB[31:2]);
    assign mispredict = reset && bus.BranchB && (wrong_dir || wrong_tgt);

    assign redirect_pc = bus.ZeroB ? {bus.TargetB[31:2], 2'b00} : pc_plus4(bus.PCB);

    // Taken branches train the BTB whether or not fetch is stalled.
    assign btb_wr = bus.BranchB && bus.ZeroB;

    always_comb begin
        pc_next = pc_q;
        if (mispredict) begin
            pc_next = redirect_pc;
        end else if (!bus.StallF) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign bus.PCF         = pc_q;
    assign bus.BTBHitF     = hit;
    assign bus.PredTakenF  = bus.BP && hit;
    assign bus.PredTargetF = pred_target;
    assign bus.MispredictB = mispredict;

    assign unused_low_bits = ^{bus.PredTargetB[1:0], bus.TargetB[1:0]};

endmodule

// File: tb/tb_fetch_pc_btb.sv
// tb/tb_fetch_pc_btb.sv - randomized and directed self-checking bench for fetch_pc_btb
module tb_fetch_pc_btb;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_pc_btb_if bus_i ();

    fetch_pc_btb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i.slave)
    );

    always #5 clk = ~clk;

    // Reference model: PC plus a 32-entry table of whole addresses.
    bit [31:0] m_pc;
    bit        m_valid [32];
    bit [31:0] m_tag   [32];
    bit [31:0] m_tgt   [32];

    function automatic int m_idx(bit [31:0] pc);
        return int'((pc / 4) % 32);
    endfunction

    function automatic bit m_hit(bit [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 128);
    endfunction

    function automatic bit [31:0] m_ptarget(bit [31:0] pc);
        return m_hit(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_misp();
        bit [31:0] t;
        bit [31:0] p;
        t = bus_i.TargetB;
        p = bus_i.PredTargetB;
        if (!reset || !bus_i.BranchB) return 1'b0;
        if (bus_i.ZeroB != bus_i.PredTakenB) return 1'b1;
        return bus_i.ZeroB && (t / 4 != p / 4);
    endfunction

    task automatic idle();
        bus_i.StallF      = 1'b0;
        bus_i.BP          = 1'b0;
        bus_i.BranchB     = 1'b0;
        bus_i.ZeroB       = 1'b0;
        bus_i.PCB         = 32'h0;
        bus_i.TargetB     = 32'h0;
        bus_i.PredTakenB  = 1'b0;
        bus_i.PredTargetB = 32'h0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge; ends just after negedge.
    task automatic cycle();
        bit [31:0] npc;
        bit        wr;
        bit [31:0] wpc;
        bit [31:0] wtgt;
        npc  = m_pc;
        if (m_misp()) npc = bus_i.ZeroB ? (bus_i.TargetB & 32'hFFFF_FFFC) : bus_i.PCB + 32'd4;
        else if (!bus_i.StallF) npc = m_ptarget(m_pc);
        wr   = bus_i.BranchB && bus_i.ZeroB;
        wpc  = bus_i.PCB;
        wtgt = bus_i.TargetB & 32'hFFFF_FFFC;
        @(posedge clk);
        if (reset) begin
            m_pc = npc;
            if (wr) begin
                m_valid[m_idx(wpc)] = 1'b1;
                m_tag[m_idx(wpc)]   = wpc / 128;
                m_tgt[m_idx(wpc)]   = wtgt;
            end
        end
        @(negedge clk);
        #1;
    endtask

    // Not-taken branch that was predicted taken: forces PCF to target on the next edge.
    task automatic redirect(bit [31:0] pc);
        idle();
        bus_i.BranchB    = 1'b1;
        bus_i.PredTakenB = 1'b1;
        bus_i.PCB        = pc - 32'd4;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        m_pc = 32'h0;
        repeat (2) cycle();
        reset = 1'b1;
        repeat (3) cycle();
        bus_i.BranchB = 1'b1; bus_i.ZeroB = 1'b1; bus_i.PCB = 32'h10; bus_i.TargetB = 32'h40;
        cycle();
        bus_i.PCB = 32'h20; bus_i.TargetB = 32'h300;
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        m_pc = 32'h0;
        #1;
        n_vec++; if (bus_i.PCF !== 32'h0) begin n_err++; $display("FAIL rst_pcf got %h want %h", bus_i.PCF, 32'h0); end
        n_vec++; if (bus_i.BTBHitF !== 1'b0) begin n_err++; $display("FAIL rst_hit got %b want 0", bus_i.BTBHitF); end
        n_vec++; if (bus_i.MispredictB !== 1'b0) begin n_err++; $display("FAIL rst_misp got %b want 0", bus_i.MispredictB); end
        n_vec++; if (bus_i.PredTargetF !== 32'h4) begin n_err++; $display("FAIL rst_ptgt got %h want %h", bus_i.PredTargetF, 32'h4); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h0) begin n_err++; $display("FAIL rst_hold got %h want %h", bus_i.PCF, 32'h0); end
        reset = 1'b1;
        idle();
        #1;
        n_vec++; if (bus_i.PCF !== 32'h0) begin n_err++; $display("FAIL rel_pc0 got %h want %h", bus_i.PCF, 32'h0); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h4) begin n_err++; $display("FAIL rel_pc4 got %h want %h", bus_i.PCF, 32'h4); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h8) begin n_err++; $display("FAIL rel_pc8 got %h want %h", bus_i.PCF, 32'h8); end
    endtask

    task automatic test_cold_taken();
        idle();
        bus_i.BranchB = 1'b1; bus_i.ZeroB = 1'b1; bus_i.PCB = 32'h10;
        bus_i.TargetB = 32'h40; bus_i.PredTargetB = 32'h14;
        #1;
        n_vec++; if (bus_i.MispredictB !== 1'b1) begin n_err++; $display("FAIL cold_misp got %b want 1", bus_i.MispredictB); end
        cycle();
        idle();
        n_vec++; if (bus_i.PCF !== 32'h40) begin n_err++; $display("FAIL cold_pcf got %h want %h", bus_i.PCF, 32'h40); end
        redirect(32'h10);
        bus_i.BP = 1'b1;
        #1;
        n_vec++; if (bus_i.BTBHitF !== 1'b1) begin n_err++; $display("FAIL cold_hit got %b want 1", bus_i.BTBHitF); end
        n_vec++; if (bus_i.PredTakenF !== 1'b1) begin n_err++; $display("FAIL cold_ptaken got %b want 1", bus_i.PredTakenF); end
        n_vec++; if (bus_i.PredTargetF !== 32'h40) begin n_err++; $display("FAIL cold_ptgt got %h want %h", bus_i.PredTargetF, 32'h40); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h40) begin n_err++; $display("FAIL cold_next got %h want %h", bus_i.PCF, 32'h40); end
    endtask

    task automatic test_alias();
        redirect(32'h90);
        bus_i.BP = 1'b1;
        #1;
        n_vec++; if (bus_i.BTBHitF !== 1'b0) begin n_err++; $display("FAIL alias_hit got %b want 0", bus_i.BTBHitF); end
        n_vec++; if (bus_i.PredTakenF !== 1'b0) begin n_err++; $display("FAIL alias_ptaken got %b want 0", bus_i.PredTakenF); end
        n_vec++; if (bus_i.PredTargetF !== 32'h94) begin n_err++; $display("FAIL alias_ptgt got %h want %h", bus_i.PredTargetF, 32'h94); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h94) begin n_err++; $display("FAIL alias_next got %h want %h", bus_i.PCF, 32'h94); end
    endtask

    task automatic test_not_taken();
        idle();
        bus_i.BranchB = 1'b1; bus_i.PCB = 32'h10; bus_i.PredTakenB = 1'b1; bus_i.PredTargetB = 32'h40;
        #1;
        n_vec++; if (bus_i.MispredictB !== 1'b1) begin n_err++; $display("FAIL nt_misp got %b want 1", bus_i.MispredictB); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h14) begin n_err++; $display("FAIL nt_pcf got %h want %h", bus_i.PCF, 32'h14); end
        redirect(32'h10);
        #1;
        n_vec++; if (bus_i.PredTargetF !== 32'h40) begin n_err++; $display("FAIL nt_kept got %h want %h", bus_i.PredTargetF, 32'h40); end
    endtask

    task automatic test_wrong_target();
        idle();
        bus_i.BranchB = 1'b1; bus_i.ZeroB = 1'b1; bus_i.PredTakenB = 1'b1;
        bus_i.PCB = 32'h10; bus_i.PredTargetB = 32'h40; bus_i.TargetB = 32'h80;
        #1;
        n_vec++; if (bus_i.MispredictB !== 1'b1) begin n_err++; $display("FAIL wt_misp got %b want 1", bus_i.MispredictB); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h80) begin n_err++; $display("FAIL wt_pcf got %h want %h", bus_i.PCF, 32'h80); end
        redirect(32'h10);
        #1;
        n_vec++; if (bus_i.PredTargetF !== 32'h80) begin n_err++; $display("FAIL wt_entry got %h want %h", bus_i.PredTargetF, 32'h80); end
        bus_i.BranchB = 1'b1; bus_i.ZeroB = 1'b1; bus_i.PredTakenB = 1'b1;
        bus_i.PCB = 32'h10; bus_i.PredTargetB = 32'h80; bus_i.TargetB = 32'h83;
        #1;
        n_vec++; if (bus_i.MispredictB !== 1'b0) begin n_err++; $display("FAIL wt_lowbits got %b want 0", bus_i.MispredictB); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h80) begin n_err++; $display("FAIL wt_follow got %h want %h", bus_i.PCF, 32'h80); end
    endtask

    task automatic test_stall_wrap();
        bit [31:0] held;
        idle();
        bus_i.StallF = 1'b1;
        held = bus_i.PCF;
        cycle();
        n_vec++; if (bus_i.PCF !== held) begin n_err++; $display("FAIL stall_hold got %h want %h", bus_i.PCF, held); end
        bus_i.BranchB = 1'b1; bus_i.PredTakenB = 1'b1; bus_i.PCB = 32'h200;
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h204) begin n_err++; $display("FAIL stall_redir got %h want %h", bus_i.PCF, 32'h204); end
        redirect(32'hFFFF_FFFC);
        #1;
        n_vec++; if (bus_i.BTBHitF !== 1'b0) begin n_err++; $display("FAIL wrap_hit got %b want 0", bus_i.BTBHitF); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h0) begin n_err++; $display("FAIL wrap_pcf got %h want %h", bus_i.PCF, 32'h0); end
    endtask

    task automatic test_same_index();
        redirect(32'h10);
        bus_i.BranchB = 1'b1; bus_i.ZeroB = 1'b1; bus_i.PredTakenB = 1'b1;
        bus_i.PCB = 32'h10; bus_i.TargetB = 32'h100; bus_i.PredTargetB = 32'h100;
        #1;
        n_vec++; if (bus_i.PredTargetF !== 32'h80) begin n_err++; $display("FAIL rw_old got %h want %h", bus_i.PredTargetF, 32'h80); end
        cycle();
        n_vec++; if (bus_i.PCF !== 32'h80) begin n_err++; $display("FAIL rw_pcf got %h want %h", bus_i.PCF, 32'h80); end
        redirect(32'h10);
        #1;
        n_vec++; if (bus_i.PredTargetF !== 32'h100) begin n_err++; $display("FAIL rw_new got %h want %h", bus_i.PredTargetF, 32'h100); end
    endtask

    task automatic test_random();
        bit [31:0] pcb;
        for (int n = 0; n < 400; n++) begin
            pcb = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
            bus_i.StallF      = ($urandom_range(0, 3) == 0);
            bus_i.BP          = $urandom_range(0, 1);
            bus_i.BranchB     = $urandom_range(0, 1);
            bus_i.ZeroB       = $urandom_range(0, 1);
            bus_i.PCB         = pcb;
            bus_i.TargetB     = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            bus_i.PredTakenB  = $urandom_range(0, 1);
            bus_i.PredTargetB = ($urandom_range(0, 1) == 1) ? (bus_i.TargetB ^ $urandom_range(0, 3))
                                                            : ($urandom_range(0, 511) << 2);
            #1;
            n_vec++; if (bus_i.PCF !== m_pc) begin n_err++; $display("FAIL rnd_pcf@%0d got %h want %h", n, bus_i.PCF, m_pc); end
            n_vec++; if (bus_i.BTBHitF !== m_hit(m_pc)) begin n_err++; $display("FAIL rnd_hit@%0d got %b want %b", n, bus_i.BTBHitF, m_hit(m_pc)); end
            n_vec++; if (bus_i.PredTakenF !== (bus_i.BP && m_hit(m_pc))) begin n_err++; $display("FAIL rnd_ptaken@%0d got %b want %b", n, bus_i.PredTakenF, bus_i.BP && m_hit(m_pc)); end
            n_vec++; if (bus_i.PredTargetF !== m_ptarget(m_pc)) begin n_err++; $display("FAIL rnd_ptgt@%0d got %h want %h", n, bus_i.PredTargetF, m_ptarget(m_pc)); end
            n_vec++; if (bus_i.MispredictB !== m_misp()) begin n_err++; $display("FAIL rnd_misp@%0d got %b want %b", n, bus_i.MispredictB, m_misp()); end
            cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_cold_taken();
        test_alias();
        test_not_taken();
        test_wrong_target();
        test_stall_wrap();
        test_same_index();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
